// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between pipe_ctrl (master) and the core datapath/CSR file (slave).
// dmem_req/dmem_ack: req is held high from the first request cycle until the cycle ack is seen
// (or a timeout fires); the access completes in the cycle where req & ack are both high.
interface pipe_ctrl_if;
  logic       rd_en_mw;
  logic       wr_en_mw;
  logic       is_mret_mw;
  logic       br_taken;
  logic       intr_pending;
  logic       dmem_ack;
  logic       dmem_req;
  logic       en_pc;
  logic       en_fe;
  logic       en_mw;
  logic       flush_fe;
  logic [1:0] pc_sel;
  logic       trap_take;
  logic       mret_take;
  logic       bus_err;

  modport master (
    input  rd_en_mw, wr_en_mw, is_mret_mw, br_taken, intr_pending, dmem_ack,
    output dmem_req, en_pc, en_fe, en_mw, flush_fe, pc_sel, trap_take, mret_take, bus_err
  );

  modport slave (
    output rd_en_mw, wr_en_mw, is_mret_mw, br_taken, intr_pending, dmem_ack,
    input  dmem_req, en_pc, en_fe, en_mw, flush_fe, pc_sel, trap_take, mret_take, bus_err
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, flushes, next-PC select and data-memory handshake.
// Optional data-access timeout enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus,
  output logic         o_dbg_state
);

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_mem_op;
  logic       w_req;
  logic       w_stall;
  logic       w_timeout;
  logic       w_adv_err;
  logic       w_en;
  logic       w_flush;
  logic       w_trap;
  logic       w_mret;
  logic [1:0] w_pc_sel;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("pipe_ctrl: TIMEOUT must be at least 2");
  end

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_timeout = (r_state == S_MEM_WAIT) && (r_cnt == CNT_LAST);

  // Reaching CNT_LAST forces the exit, so the increment never passes it.
  always_comb begin
    w_cnt_nxt = '0;
    if ((r_state == S_MEM_WAIT) && !bus.dmem_ack && !w_timeout) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_mem_op    = bus.rd_en_mw | bus.wr_en_mw;
    w_req       = ((r_state == S_RUN) && w_mem_op) || (r_state == S_MEM_WAIT);
    w_stall     = w_req && !bus.dmem_ack && !w_timeout;
    w_adv_err   = w_timeout && !bus.dmem_ack;
    w_state_nxt = r_state;
    w_en        = 1'b0;
    w_flush     = 1'b0;
    w_trap      = 1'b0;
    w_mret      = 1'b0;
    w_pc_sel    = 2'd0;

    case (r_state)
      S_RUN:      if (w_mem_op && !bus.dmem_ack) w_state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: if (bus.dmem_ack || w_timeout) w_state_nxt = S_RUN;
      default:    w_state_nxt = S_RUN;
    endcase

    // An mret that shares its cycle with a memory op commits only once the access advances.
    if (!w_stall) begin
      w_en = 1'b1;
      if (bus.intr_pending && !bus.is_mret_mw) begin
        w_trap   = 1'b1;
        w_pc_sel = 2'd2;
        w_flush  = 1'b1;
      end else if (bus.is_mret_mw) begin
        w_mret   = 1'b1;
        w_pc_sel = 2'd3;
        w_flush  = 1'b1;
      end else if (bus.br_taken) begin
        w_pc_sel = 2'd1;
        w_flush  = 1'b1;
      end
      if (w_adv_err) begin
        w_flush = 1'b1;
      end
    end
  end

  // Outputs are held low for the whole reset window, whatever the inputs do.
  assign bus.dmem_req  = w_req     & ~rst;
  assign bus.en_pc     = w_en      & ~rst;
  assign bus.en_fe     = w_en      & ~rst;
  assign bus.en_mw     = w_en      & ~rst;
  assign bus.flush_fe  = w_flush   & ~rst;
  assign bus.pc_sel    = rst ? 2'd0 : w_pc_sel;
  assign bus.trap_take = w_trap    & ~rst;
  assign bus.mret_take = w_mret    & ~rst;
  assign bus.bus_err   = w_adv_err & ~rst;
  assign o_dbg_state   = (r_state == S_MEM_WAIT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: hand-computed output vectors per cycle, checked mid-cycle.
// Output vector layout: {dmem_req, en_pc, en_fe, en_mw, flush_fe, pc_sel[1:0], trap_take, mret_take, bus_err}.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;

  // Input vector layout: {rd, wr, mret, br, intr, ack}
  localparam logic [5:0] I_NONE   = 6'b000000;
  localparam logic [5:0] I_LD     = 6'b100000;
  localparam logic [5:0] I_LD_ACK = 6'b100001;
  localparam logic [5:0] I_ST     = 6'b010000;
  localparam logic [5:0] I_ST_ACK = 6'b010001;
  localparam logic [5:0] I_BR     = 6'b000100;
  localparam logic [5:0] I_BR_INT = 6'b000110;
  localparam logic [5:0] I_MRET   = 6'b001000;
  localparam logic [5:0] I_MR_INT = 6'b001010;
  localparam logic [5:0] I_MR_LD  = 6'b101000;
  localparam logic [5:0] I_MR_LDA = 6'b101001;
  localparam logic [5:0] I_ALL    = 6'b111111;

  localparam logic [9:0] O_ZERO   = 10'b0_000_0_00_000;
  localparam logic [9:0] O_IDLE   = 10'b0_111_0_00_000;
  localparam logic [9:0] O_STALL  = 10'b1_000_0_00_000;
  localparam logic [9:0] O_MEMADV = 10'b1_111_0_00_000;
  localparam logic [9:0] O_TRAP   = 10'b0_111_1_10_100;
  localparam logic [9:0] O_MRET   = 10'b0_111_1_11_010;
  localparam logic [9:0] O_BRANCH = 10'b0_111_1_01_000;
  localparam logic [9:0] O_MR_MEM = 10'b1_111_1_11_010;
  localparam logic [9:0] O_TMO    = 10'b1_111_1_00_001;

  localparam logic ST_RUN = 1'b0;
  localparam logic ST_MW  = 1'b1;

  logic clk;
  logic rst;
  logic dbg_state;
  logic [9:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  pipe_ctrl_if bus ();

  pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  assign obs = {bus.dmem_req, bus.en_pc, bus.en_fe, bus.en_mw, bus.flush_fe,
                bus.pc_sel, bus.trap_take, bus.mret_take, bus.bus_err};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic apply(input logic [5:0] in_v);
    {bus.rd_en_mw, bus.wr_en_mw, bus.is_mret_mw, bus.br_taken, bus.intr_pending, bus.dmem_ack} = in_v;
  endtask

  task automatic check_out(input string tag, input logic [9:0] exp_v, input logic exp_st);
    logic [9:0] e;
    exp_q.push_back(exp_v);
    e = exp_q.pop_front();
    check({tag, ".out"}, 32'(obs), 32'(e));
    check({tag, ".state"}, 32'(dbg_state), 32'(exp_st));
  endtask

  // Drive one cycle's inputs just after the edge, check mid-cycle, then move to the next edge.
  task automatic cycle(input string tag, input logic [5:0] in_v, input logic [9:0] exp_v,
                       input logic exp_st);
    apply(in_v);
    #3;
    check_out(tag, exp_v, exp_st);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    apply(I_ALL);
    #3;
    check_out("reset_all_in", O_ZERO, ST_RUN);
    @(posedge clk);
    #1;
    check_out("reset_hold", O_ZERO, ST_RUN);
    apply(I_NONE);
    rst = 1'b0;

    cycle("idle", I_NONE, O_IDLE, ST_RUN);

    // Zero-wait load
    cycle("ld_ack0", I_LD_ACK, O_MEMADV, ST_RUN);
    cycle("ld_ack0_after", I_NONE, O_IDLE, ST_RUN);

    // Store acked three cycles after the request
    cycle("st_w0", I_ST, O_STALL, ST_RUN);
    cycle("st_w1", I_ST, O_STALL, ST_MW);
    cycle("st_w2", I_ST, O_STALL, ST_MW);
    cycle("st_ack", I_ST_ACK, O_MEMADV, ST_MW);
    cycle("st_after", I_NONE, O_IDLE, ST_RUN);

    // Control-flow priorities
    cycle("br_and_intr", I_BR_INT, O_TRAP, ST_RUN);
    cycle("trap_one_cycle", I_NONE, O_IDLE, ST_RUN);
    cycle("mret", I_MRET, O_MRET, ST_RUN);
    cycle("mret_one_cycle", I_NONE, O_IDLE, ST_RUN);
    cycle("branch", I_BR, O_BRANCH, ST_RUN);
    cycle("mret_over_intr", I_MR_INT, O_MRET, ST_RUN);

    // mret alongside a load: handshake first, mret on the advance
    cycle("mret_ld_w0", I_MR_LD, O_STALL, ST_RUN);
    cycle("mret_ld_ack", I_MR_LDA, O_MR_MEM, ST_MW);
    cycle("mret_ld_after", I_NONE, O_IDLE, ST_RUN);

    // Load with no ack
    cycle("noack_w0", I_LD, O_STALL, ST_RUN);
    cycle("noack_w1", I_LD, O_STALL, ST_MW);
    cycle("noack_w2", I_LD, O_STALL, ST_MW);
    cycle("noack_w3", I_LD, O_STALL, ST_MW);
`ifdef PIPE_CTRL_TIMEOUT_EN
    cycle("timeout_adv", I_LD, O_TMO, ST_MW);
    cycle("timeout_after", I_NONE, O_IDLE, ST_RUN);
`else
    cycle("noack_w4", I_LD, O_STALL, ST_MW);
    cycle("noack_w5", I_LD, O_STALL, ST_MW);
    cycle("noack_w6", I_LD, O_STALL, ST_MW);
    cycle("noack_ack", I_LD_ACK, O_MEMADV, ST_MW);
    cycle("noack_after", I_NONE, O_IDLE, ST_RUN);
`endif

    // Reset pulsed mid-MEM_WAIT
    cycle("rst_mw_w0", I_ST, O_STALL, ST_RUN);
    cycle("rst_mw_w1", I_ST, O_STALL, ST_MW);
    rst = 1'b1;
    #2;
    check_out("rst_async", O_ZERO, ST_RUN);
    @(posedge clk);
    #1;
    check_out("rst_async_hold", O_ZERO, ST_RUN);
    rst = 1'b0;
    cycle("rst_rel_req", I_ST, O_STALL, ST_RUN);
    cycle("rst_rel_ack", I_ST_ACK, O_MEMADV, ST_MW);
    cycle("rst_rel_after", I_NONE, O_IDLE, ST_RUN);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
